// File: rtl/mdu_div.sv
// mdu_div: iterative 32-bit restoring divider (DIV/DIVU) for the EX stage.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   start          begin a division (sampled in IDLE only)
//   signed_op      1 = DIV (two's complement), 0 = DIVU
//   annul          pipeline flush, aborts any operation in progress
//   dividend       rs operand
//   divisor        rt operand
//   stall_req      holds the pipeline while the division is in flight
//   ready          one-cycle pulse, result valid
//   busy           high in CALC and DONE
//   result         {remainder, quotient}
module mdu_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic        annul,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        stall_req,
    output logic        ready,
    output logic        busy,
    output logic [63:0] result
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] div_q, div_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] result_q, result_d;

    logic [31:0] abs_a, abs_b;
    logic [32:0] shifted, diff;
    logic [31:0] step_rem, step_quo;

    // Negating 32'h80000000 wraps to itself, which is exactly its unsigned magnitude.
    assign abs_a = (signed_op && dividend[31]) ? 32'd0 - dividend : dividend;
    assign abs_b = (signed_op && divisor[31]) ? 32'd0 - divisor : divisor;

    // quo_q doubles as the dividend shift register: its MSB feeds the remainder
    // while the new quotient bit enters at the LSB.
    assign shifted  = {rem_q, quo_q[31]};
    assign diff     = shifted - {1'b0, div_q};
    assign step_rem = diff[32] ? shifted[31:0] : diff[31:0];
    assign step_quo = {quo_q[30:0], ~diff[32]};

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (start && !annul) begin
                    if (divisor == 32'd0) begin
                        state_d  = DONE;
                        result_d = {dividend, 32'hFFFF_FFFF};
                    end else begin
                        state_d   = CALC;
                        count_d   = 5'd0;
                        rem_d     = 32'd0;
                        quo_d     = abs_a;
                        div_d     = abs_b;
                        neg_quo_d = signed_op && (dividend[31] ^ divisor[31]);
                        neg_rem_d = signed_op && dividend[31];
                    end
                end
            end
            CALC: begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d  = DONE;
                    result_d = {neg_rem_q ? 32'd0 - step_rem : step_rem,
                                neg_quo_q ? 32'd0 - step_quo : step_quo};
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (annul) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= 5'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            div_q     <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= 64'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    // DONE drops stall so the requesting instruction advances with the result.
    assign stall_req = (state_q == IDLE && start && !annul) || state_q == CALC;
    assign ready     = state_q == DONE && !annul;
    assign busy      = state_q != IDLE;
    assign result    = result_q;
endmodule

// File: tb/tb_mdu_div.sv
// tb_mdu_div: directed scoreboard bench for mdu_div.
module tb_mdu_div;
    logic        clk = 1'b0;
    logic        rst, start, signed_op, annul;
    logic [31:0] dividend, divisor;
    logic        stall_req, ready, busy;
    logic [63:0] result;

    logic [63:0] exp_q[$];
    logic [63:0] last_res;
    int          n_chk = 0;
    int          n_fail = 0;

    mdu_div dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op), .annul(annul),
        .dividend(dividend), .divisor(divisor), .stall_req(stall_req),
        .ready(ready), .busy(busy), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", n, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (ready) begin
            if (exp_q.size() == 0) check("unexpected_ready", 64'd1, 64'd0);
            else check("result", result, exp_q.pop_front());
        end
    end

    // Issues a division in the current cycle T and checks cycle-by-cycle timing up to
    // the ready pulse at T+lat; with noise, start is held high with junk operands during CALC.
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat, input bit noise);
        signed_op = s; dividend = a; divisor = b; start = 1'b1;
        exp_q.push_back(exp);
        #1 check("stall_T", stall_req, 1);
        tick;
        start = 1'b0;
        for (int i = 1; i < lat; i++) begin
            if (noise) begin
                start = 1'b1; dividend = $urandom; divisor = $urandom_range(1, 1000);
            end
            #1;
            check("ready_calc", ready, 0);
            check("stall_calc", stall_req, 1);
            check("busy_calc", busy, 1);
            tick;
        end
        start = 1'b0;
        #1;
        check("ready_done", ready, 1);
        check("stall_done", stall_req, 0);
        check("busy_done", busy, 1);
        tick;
        last_res = exp;
        check("busy_idle", busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; signed_op = 1'b0; annul = 1'b0;
        dividend = 32'd0; divisor = 32'd0; last_res = 64'd0;
        tick; tick;
        check("rst_result", result, 64'd0);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_stall", stall_req, 0);
        rst = 1'b0;
        tick;

        do_div(0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0);
        do_div(1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
        do_div(1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33, 0);
        do_div(1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'd3}, 33, 0);
        do_div(0, 32'hFFFF_FFF9, 32'd2, {32'd1, 32'h7FFF_FFFC}, 33, 0);
        do_div(0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1, 0);
        do_div(1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1, 0);
        do_div(1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, 0);
        do_div(0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 33, 0);
        do_div(0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33, 0);
        do_div(0, 32'd3, 32'd10, {32'd3, 32'd0}, 33, 0);
        do_div(0, 32'd1000, 32'd33, {32'd10, 32'd30}, 33, 1);

        // annul at T+10 aborts; restart at T+12 finishes at T+45
        signed_op = 1'b0; dividend = 32'd50; divisor = 32'd3; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick;
        annul = 1'b1;
        #1 check("annul_ready", ready, 0);
        tick;
        annul = 1'b0;
        check("annul_busy", busy, 0);
        check("annul_stall", stall_req, 0);
        check("annul_result", result, last_res);
        tick;
        do_div(0, 32'd50, 32'd3, {32'd2, 32'd16}, 33, 0);

        // annul together with start in IDLE must not launch
        start = 1'b1; annul = 1'b1; divisor = 32'd0;
        #1 check("annul_start_stall", stall_req, 0);
        tick;
        start = 1'b0; annul = 1'b0;
        check("annul_start_busy", busy, 0);
        check("annul_start_result", result, last_res);

        // reset mid-CALC clears everything without a ready pulse
        signed_op = 1'b0; dividend = 32'd77; divisor = 32'd5; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 1; i < 6; i++) tick;
        rst = 1'b1;
        tick;
        check("midrst_result", result, 64'd0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", ready, 0);
        check("midrst_stall", stall_req, 0);
        rst = 1'b0;
        tick;
        do_div(0, 32'd77, 32'd5, {32'd2, 32'd15}, 33, 0);

        tick; tick;
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mdu_div.md
MDU_DIV -- requirements
Module: mdu_div

Interface
REQ-001 clk  input  1  clock; all state updates on posedge clk.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 start  input  1  EX-stage request to begin a division; sampled only in IDLE.
REQ-004 signed_op  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
REQ-005 annul  input  1  flush from the pipeline; aborts any operation in progress.
REQ-006 dividend  input  32  operand rs; sampled with start.
REQ-007 divisor  input  32  operand rt; sampled with start.
REQ-008 stall_req  output  1  pipeline stall request while the division is in flight.
REQ-009 ready  output  1  one-cycle pulse; result is valid in this cycle.
REQ-010 busy  output  1  high in CALC and DONE states.
REQ-011 result  output  64  {hi = remainder[31:0], lo = quotient[31:0]}; feeds the lo_hi EX-to-WB bus.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, CALC, and DONE.
REQ-013 IDLE with start=1, annul=0, and divisor!=0: latch the operands, enter CALC with count=0.
REQ-014 IDLE with start=1, annul=0, and divisor==0: enter DONE directly with quotient=32'hFFFFFFFF and remainder=dividend (raw operand, regardless of signed_op).
REQ-015 Signed mode: internal operands are the absolute values; abs(32'h80000000) SHALL be taken as unsigned 32'h80000000.
REQ-016 CALC: perform one restoring step per cycle.
  - Shift the 33-bit partial remainder left, bringing in the next dividend bit from the MSB.
  - Subtract the divisor; if the result is non-negative, keep it and set the quotient bit to 1, else restore and set it to 0.
REQ-017 CALC SHALL last exactly 32 cycles (count 0..31), then enter DONE.
REQ-018 On entering DONE in signed mode:
  - Negate the quotient when the operand signs differ.
  - Negate the remainder when the dividend is negative.
REQ-019 Signed 32'h80000000 / 32'hFFFFFFFF SHALL yield quotient 32'h80000000 and remainder 0 (wrap, no trap).
REQ-020 DONE SHALL last one cycle with ready=1, then return to IDLE.
REQ-021 Latency: start accepted in cycle T gives ready in cycle T+33 (T+1 when divisor==0).
REQ-022 stall_req SHALL be combinationally high:
  - in IDLE when start=1 and annul=0;
  - throughout CALC;
  - low in DONE, so the requesting instruction advances with the result.
REQ-023 start asserted outside IDLE SHALL be ignored; operands are not re-sampled.
REQ-024 annul=1 in any state SHALL force IDLE on the next edge.
  - ready stays 0 during that cycle.
  - result holds its previous value.
  - annul together with start in IDLE SHALL not start an operation.
REQ-025 result SHALL update only on entry to DONE and hold stable until the next DONE.
REQ-026 result SHALL be computed with width-exact arithmetic: 33-bit remainder datapath, 32-bit quotient register.

Reset
REQ-027 On rst:
  - state=IDLE, count=0, result=64'h0;
  - ready=0, busy=0, stall_req=0;
  - internal operand and sign registers=0.
REQ-028 rst SHALL take priority over annul and start.
REQ-029 rst asserted mid-CALC SHALL abort with no ready pulse and result=0.

Verification
REQ-030 Unsigned: start, DIVU 100/7 at T -> stall_req high T..T+32, ready at T+33, result={32'd2,32'd14}.
REQ-031 Signed: DIV -7/2 -> result={32'hFFFFFFFF,32'hFFFFFFFD}; DIV 7/-2 -> {32'd1,32'hFFFFFFFD}.
REQ-032 Divide by zero: DIVU 5/0 at T -> ready at T+1, result={32'd5,32'hFFFFFFFF}, stall_req high only in cycle T.
REQ-033 Overflow: DIV 32'h80000000/32'hFFFFFFFF -> result={32'h0,32'h80000000} after 33 cycles.
REQ-034 Abort: annul at cycle T+10 of a division -> IDLE at T+11, no ready pulse, result unchanged.
  - A new start at T+12 completes normally at T+45.
REQ-035 Ignored start and reset:
  - start pulses during CALC with different operands -> original result returned.
  - rst mid-CALC -> all outputs 0 on the next cycle.
